// File: rtl/cpu_mem_responder_pkg.sv
// Shared types for the CPU memory responder: FSM states, port select and
// the latched transaction record.
package cpu_mem_responder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } mem_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_sel_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [3:0]  byte_enable;
        logic [31:0] address;
        logic [31:0] wdata;
    } mem_req_t;

    // A port asserting read and write together is treated as a write.
    function automatic mem_req_t make_req(input logic        rd,
                                          input logic        wr,
                                          input logic [3:0]  be,
                                          input logic [31:0] addr,
                                          input logic [31:0] wd);
        mem_req_t r;
        r.read        = rd & ~wr;
        r.write       = wr;
        r.byte_enable = be;
        r.address     = addr;
        r.wdata       = wd;
        return r;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the port not granted last time wins.
module rr_arbiter2
    import cpu_mem_responder_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      req_i,
    input  logic      req_d,
    input  logic      accept,
    output port_sel_t grant
);

    port_sel_t last_grant_q, last_grant_d;

    always_comb begin
        grant = PORT_I;
        if (req_i && req_d) begin
            grant = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d) begin
            grant = PORT_D;
        end
        last_grant_d = accept ? grant : last_grant_q;
    end

    // Reset to PORT_I so the D port wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PORT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Arbitrates the CPU I and D memory ports onto one physical memory port,
// one transaction at a time, with a sticky timeout flag.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [3:0]  mem_byte_enable_i,
    input  logic [31:0] mem_address_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_resp_i,
    output logic [31:0] mem_rdata_i,
    input  logic        mem_read_d,
    input  logic        mem_write_d,
    input  logic [3:0]  mem_byte_enable_d,
    input  logic [31:0] mem_address_d,
    input  logic [31:0] mem_wdata_d,
    output logic        mem_resp_d,
    output logic [31:0] mem_rdata_d,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [3:0]  pmem_byte_enable,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    mem_state_t       state_q, state_d;
    mem_req_t         txn_q, txn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;
    logic [31:0]      rdata_ip_q, rdata_ip_d;
    logic [31:0]      rdata_dp_q, rdata_dp_d;
    logic             pend_i, pend_d, accept, busy;
    port_sel_t        grant;

    assign pend_i  = mem_read_i | mem_write_i;
    assign pend_d  = mem_read_d | mem_write_d;
    assign cnt_inc = cnt_q + CNT_W'(1);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (pend_i),
        .req_d  (pend_d),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_ip_d = rdata_ip_q;
        rdata_dp_d = rdata_dp_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_i || pend_d) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    if (grant == PORT_D) begin
                        txn_d   = make_req(mem_read_d, mem_write_d, mem_byte_enable_d,
                                           mem_address_d, mem_wdata_d);
                        state_d = BUSY_D;
                    end else begin
                        txn_d   = make_req(mem_read_i, mem_write_i, mem_byte_enable_i,
                                           mem_address_i, mem_wdata_i);
                        state_d = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    cnt_d = '0;
                    if (txn_q.read) begin
                        if (state_q == BUSY_I) rdata_ip_d = pmem_rdata;
                        else                   rdata_dp_d = pmem_rdata;
                    end
                    state_d = (state_q == BUSY_I) ? RESP_I : RESP_D;
                end else if (cnt_q != TO_CNT) begin
                    // Flag on the edge the counter reaches TIMEOUT, then saturate.
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_CNT) err_d = 1'b1;
                end
            end
            RESP_I, RESP_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            txn_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_ip_q <= '0;
            rdata_dp_q <= '0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_ip_q <= rdata_ip_d;
            rdata_dp_q <= rdata_dp_d;
        end
    end

    assign busy             = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign pmem_read        = busy & txn_q.read;
    assign pmem_write       = busy & txn_q.write;
    assign pmem_byte_enable = txn_q.byte_enable;
    assign pmem_address     = txn_q.address;
    assign pmem_wdata       = txn_q.wdata;
    assign mem_resp_i       = (state_q == RESP_I);
    assign mem_resp_d       = (state_q == RESP_D);
    assign mem_rdata_i      = rdata_ip_q;
    assign mem_rdata_d      = rdata_dp_q;
    assign err_timeout      = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: a vector table of single transactions
// plus hand-written arbitration, blocking, timeout and reset sequences.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read_i = 0, mem_write_i = 0;
    logic [3:0]  mem_byte_enable_i = 0;
    logic [31:0] mem_address_i = 0, mem_wdata_i = 0;
    logic        mem_resp_i;
    logic [31:0] mem_rdata_i;
    logic        mem_read_d = 0, mem_write_d = 0;
    logic [3:0]  mem_byte_enable_d = 0;
    logic [31:0] mem_address_d = 0, mem_wdata_d = 0;
    logic        mem_resp_d;
    logic [31:0] mem_rdata_d;
    logic        pmem_read, pmem_write;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_address, pmem_wdata;
    logic        pmem_resp = 0;
    logic [31:0] pmem_rdata = 0;
    logic        err_timeout;

    cpu_mem_responder #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_byte_enable_i(mem_byte_enable_i), .mem_address_i(mem_address_i),
        .mem_wdata_i(mem_wdata_i), .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i),
        .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
        .mem_byte_enable_d(mem_byte_enable_d), .mem_address_d(mem_address_d),
        .mem_wdata_d(mem_wdata_d), .mem_resp_d(mem_resp_d), .mem_rdata_d(mem_rdata_d),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_byte_enable(pmem_byte_enable), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] pdata;
        logic        exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic set_port(input logic is_d, input logic rd, input logic wr,
                            input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        if (is_d) begin
            mem_read_d = rd; mem_write_d = wr; mem_byte_enable_d = be;
            mem_address_d = addr; mem_wdata_d = wd;
        end else begin
            mem_read_i = rd; mem_write_i = wr; mem_byte_enable_i = be;
            mem_address_i = addr; mem_wdata_i = wd;
        end
    endtask

    // One transaction on one port with a pmem model answering after v.lat BUSY cycles.
    task automatic run_txn(input string tag, input vec_t v);
        int n = 0, busy = 0, resp_at = 0;
        bit bad_pmem = 0, bad_other = 0, seen = 0;
        logic [31:0] rdata = 0;
        @(posedge clk); #1;
        set_port(v.is_d, v.rd, v.wr, v.be, v.addr, v.wd);
        while (n < 200 && !seen) begin
            @(negedge clk); n++;
            pmem_resp = 0;
            if (pmem_read && pmem_write) bad_pmem = 1;
            if (pmem_read || pmem_write) begin
                busy++;
                if (pmem_write !== v.exp_wr || pmem_read !== !v.exp_wr ||
                    pmem_address !== v.addr || pmem_byte_enable !== v.be ||
                    (v.exp_wr && pmem_wdata !== v.wd)) bad_pmem = 1;
                if (busy == v.lat) begin pmem_resp = 1; pmem_rdata = v.pdata; end
            end
            if (v.is_d ? mem_resp_i : mem_resp_d) bad_other = 1;
            if (v.is_d ? mem_resp_d : mem_resp_i) begin
                seen = 1; resp_at = n;
                rdata = v.is_d ? mem_rdata_d : mem_rdata_i;
                set_port(v.is_d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end
        @(negedge clk);
        check({tag, " latency"}, resp_at, v.lat + 2);
        check({tag, " rdata"}, rdata, v.exp_rdata);
        check({tag, " pmem signals"}, {31'b0, bad_pmem}, 0);
        check({tag, " busy cycles"}, busy, v.lat);
        check({tag, " other port resp"}, {31'b0, bad_other}, 0);
        check({tag, " one-cycle resp"}, {30'b0, mem_resp_i, mem_resp_d}, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0060, 32'h0, 1, 32'h0010_0093, 1'b0, 32'h0010_0093};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_1004, 32'hDEAD_BEEF, 5, 32'h5555_5555, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0064, 32'h0, 3, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 4'b1100, 32'h0000_2004, 32'h0A0B_0C0D, 1, 32'hFFFF_FFFF, 1'b1, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_2008, 32'h1122_3344, 2, 32'h9999_9999, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 4'b0001, 32'h0000_0068, 32'h8765_4321, 2, 32'h4444_4444, 1'b1, 32'h1234_5678};

        // Reset state
        #2;
        check("reset ctl outputs", {27'b0, mem_resp_i, mem_resp_d, pmem_read, pmem_write, err_timeout}, 0);
        check("reset rdata_i", mem_rdata_i, 0);
        check("reset rdata_d", mem_rdata_d, 0);
        check("reset pmem_address", pmem_address, 0);
        @(negedge clk); @(negedge clk); rst = 1;

        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Simultaneous requests from reset: expect D, I, D, I
        begin
            int n = 0, ng = 0, nresp = 0;
            bit prev = 0, re_i = 0, re_d = 0;
            logic order [4];
            @(negedge clk); rst = 0; @(negedge clk); rst = 1;
            @(posedge clk); #1;
            set_port(1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
            set_port(1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
            while (n < 100 && nresp < 4) begin
                @(negedge clk); n++;
                pmem_resp = 0;
                if (pmem_read) begin
                    if (!prev && ng < 4) begin order[ng] = (pmem_address == 32'h200); ng++; end
                    pmem_resp = 1; pmem_rdata = pmem_address ^ 32'hA5A5_0000;
                end
                prev = pmem_read;
                if (mem_resp_d) begin nresp++; mem_read_d = 0; re_d = (nresp < 3); end
                if (mem_resp_i) begin nresp++; mem_read_i = 0; re_i = (nresp < 3); end
                @(posedge clk); #1;
                if (re_d) begin mem_read_d = 1; re_d = 0; end
                if (re_i) begin mem_read_i = 1; re_i = 0; end
            end
            check("tie grants seen", ng, 4);
            check("tie order", {28'b0, order[0], order[1], order[2], order[3]}, 32'b1010);
            check("tie rdata_d", mem_rdata_d, 32'hA5A5_0200);
            check("tie rdata_i", mem_rdata_i, 32'hA5A5_0100);
        end

        // D request arriving while I is in BUSY_I must wait
        begin
            int n = 0, busy_i = 0, t_ri = -1, t_db = -1;
            bit bad = 0, done = 0;
            @(posedge clk); #1;
            set_port(1'b0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
            while (n < 100 && !done) begin
                @(negedge clk); n++;
                pmem_resp = 0;
                if (t_ri < 0) begin
                    if (pmem_read) begin
                        busy_i++;
                        if (pmem_address !== 32'h300) bad = 1;
                        if (busy_i == 1) set_port(1'b1, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
                        if (busy_i == 4) begin pmem_resp = 1; pmem_rdata = 32'h0BAD_F00D; end
                    end
                    if (mem_resp_d) bad = 1;
                    if (mem_resp_i) begin t_ri = n; mem_read_i = 0; end
                end else begin
                    if (pmem_read && t_db < 0) begin
                        t_db = n;
                        check("block D address", pmem_address, 32'h400);
                        pmem_resp = 1; pmem_rdata = 32'h600D_CAFE;
                    end
                    if (mem_resp_d) begin mem_read_d = 0; done = 1; end
                end
            end
            check("block I held", {31'b0, bad}, 0);
            check("block I busy cycles", busy_i, 4);
            check("block D grant gap", t_db - t_ri, 2);
            check("block D done", {31'b0, done}, 1);
            check("block rdata_i", mem_rdata_i, 32'h0BAD_F00D);
            check("block rdata_d", mem_rdata_d, 32'h600D_CAFE);
        end

        // Timeout: TIMEOUT=16, pmem answers in BUSY cycle 21
        begin
            int n = 0, busy = 0;
            bit seen = 0;
            logic e16 = 1'bx, e17 = 1'bx, eresp = 1'bx;
            @(negedge clk);
            check("timeout err before", {31'b0, err_timeout}, 0);
            @(posedge clk); #1;
            set_port(1'b0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
            while (n < 100 && !seen) begin
                @(negedge clk); n++;
                pmem_resp = 0;
                if (pmem_read) begin
                    busy++;
                    if (busy == 16) e16 = err_timeout;
                    if (busy == 17) e17 = err_timeout;
                    if (busy == 21) begin pmem_resp = 1; pmem_rdata = 32'h7777_0001; end
                end
                if (mem_resp_i) begin seen = 1; eresp = err_timeout; mem_read_i = 0; end
            end
            check("timeout err at busy16", {31'b0, e16}, 0);
            check("timeout err at busy17", {31'b0, e17}, 1);
            check("timeout resp still issued", {31'b0, seen}, 1);
            check("timeout rdata_i", mem_rdata_i, 32'h7777_0001);
            check("timeout err at resp", {31'b0, eresp}, 1);
            repeat (3) @(negedge clk);
            check("timeout err sticky", {31'b0, err_timeout}, 1);
            rst = 0; #1;
            check("timeout err cleared by reset", {31'b0, err_timeout}, 0);
            @(negedge clk); rst = 1;
        end

        // Asynchronous reset in the middle of BUSY_D
        begin
            int n = 0, busy = 0;
            bit hit = 0, stray = 0;
            vec_t v;
            @(posedge clk); #1;
            set_port(1'b1, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
            while (n < 20 && !hit) begin
                @(negedge clk); n++;
                if (pmem_read) busy++;
                if (busy == 2) begin
                    hit = 1;
                    check("rst mid-busy pmem_read before", {31'b0, pmem_read}, 1);
                    rst = 0; #1;
                    check("rst mid-busy pmem req dropped", {30'b0, pmem_read, pmem_write}, 0);
                    mem_read_d = 0;
                end
            end
            check("rst mid-busy reached", {31'b0, hit}, 1);
            repeat (2) begin @(negedge clk); if (mem_resp_d) stray = 1; end
            rst = 1;
            repeat (3) begin @(negedge clk); if (mem_resp_d || pmem_read) stray = 1; end
            check("rst mid-busy no resp", {31'b0, stray}, 0);
            v = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0070, 32'h0, 2, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF};
            run_txn("post-reset I", v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's two initiator ports, instruction (i) and data (d).
- Accepts read/write requests on both ports and arbitrates between them.
- Serialises accepted requests onto one word-wide physical memory port (pmem), then returns a one-cycle mem_resp plus read data to the requesting port.
- Sits between the CPU top level and the cache/physical-memory subsystem.

Parameters:
- TIMEOUT, 1024: max cycles to wait for pmem_resp before flagging err_timeout.
- CNT_W, 11: width of the latency counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- mem_read_i  input  1  I-port read request
- mem_write_i  input  1  I-port write request (tied 0 by CPU; still served)
- mem_byte_enable_i  input  4  I-port byte enables
- mem_address_i  input  32  I-port address
- mem_wdata_i  input  32  I-port write data
- mem_resp_i  output  1  I-port completion pulse
- mem_rdata_i  output  32  I-port read data, valid while mem_resp_i=1
- mem_read_d, mem_write_d, mem_byte_enable_d, mem_address_d, mem_wdata_d  inputs  1/1/4/32/32  D-port request, same meaning as the I-port inputs
- mem_resp_d  output  1  D-port completion pulse
- mem_rdata_d  output  32  D-port read data
- pmem_read  output  1  backing read request
- pmem_write  output  1  backing write request
- pmem_byte_enable  output  4  backing byte enables
- pmem_address  output  32  backing address
- pmem_wdata  output  32  backing write data
- pmem_resp  input  1  backing completion pulse
- pmem_rdata  input  32  backing read data, valid with pmem_resp
- err_timeout  output  1  sticky timeout flag

Behaviour:
- Protocol, all ports:
  - Initiator holds request, address, wdata and byte_enable stable until it sees resp.
  - resp is exactly a one-cycle pulse.
  - Initiator may start a new request in the cycle after resp.
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; counter 0; err_timeout 0.
  - last_grant=I, so D wins the first tie.
  - Reset mid-transaction abandons it; no resp is issued.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - A request is "pending" on a port when its read|write is 1.
  - Only one port pending: grant it.
  - Both pending: grant the port that is not last_grant.
  - On grant, latch op, address, wdata and byte_enable into internal registers, update last_grant, and move to BUSY_x next cycle.
- Read/write conflict on one port: if read and write are both 1 on a port, write wins and read is ignored.
- BUSY_x:
  - pmem_read/pmem_write are driven from the latched op; pmem_* come from the latched registers, not live inputs.
  - Counter increments every cycle.
  - On pmem_resp=1: capture pmem_rdata (reads only; writes leave rdata unchanged), clear the counter, go to RESP_x.
- RESP_x:
  - mem_resp_x=1 for one cycle; mem_rdata_x holds the captured data.
  - Next state is IDLE.
  - A new request is not granted in the RESP cycle.
- Minimum latency: 3 cycles, from request visible in IDLE to resp, when pmem responds in its first cycle.
- pmem requests are never issued in IDLE or RESP. pmem_read and pmem_write are never both 1.
- Timeout:
  - If the counter reaches TIMEOUT in BUSY_x, set err_timeout=1 (sticky until reset).
  - Keep waiting; do not abort the transaction.
  - Counter saturates at TIMEOUT.
- Requests withdrawn before resp are a protocol violation. The latched transaction completes and resp is still pulsed.
- mem_rdata_x outputs are registered and hold their value between transactions.

Decomposition:
- Shared package (rv32i_types or an arbiter package):
  - mem_state_t enum for the five states.
  - port_sel_t enum {PORT_I, PORT_D}.
  - mem_req_t struct {read, write, byte_enable[4], address[32], wdata[32]}, used for the latched transaction.
- One sub-module is natural: rr_arbiter2, a 2-way round-robin grant holding last_grant. Its inputs are req_i, req_d and an accept strobe; its output is the grant.
- FSM, latch and counter stay in cpu_mem_responder.

Test Plan:
- Single I read, addr 0x00000060, pmem responds on 1st BUSY cycle with 0x00100093 -> mem_resp_i pulses 1 cycle, 3 cycles after the request, with mem_rdata_i=0x00100093; mem_resp_d stays 0.
- D write, addr 0x00001004, wdata 0xDEADBEEF, be 4'b0011, pmem latency 5 -> pmem_write=1 with those exact values for 5 cycles; one mem_resp_d pulse; pmem_read never 1.
- I and D read simultaneously from reset -> D served first, then I; repeated simultaneous requests alternate D, I, D, I.
- D read asserted while an I transaction is in BUSY_I -> pmem_address stays at the I address until mem_resp_i; D is granted in the following IDLE.
- pmem_resp withheld for TIMEOUT+5 cycles with TIMEOUT=16 -> err_timeout rises after 16 BUSY cycles and stays 1; a later pmem_resp still produces mem_resp; err_timeout clears only on rst=0.
- rst driven low mid-BUSY_D -> pmem_read/pmem_write drop immediately (asynchronous); no mem_resp_d; after release, a new I read completes normally.
